// File: rtl/ad_ip_jesd204_tpl_adc_pnmon_deframer.sv
// JESD204 ADC transport-layer receive path.
// Link beats are split into per-channel 16-bit sample words and formatted.
// Each channel is checked against a PN9/PN15 sequence, and a per-channel
// OOS/SYNC state machine reports lock and error status.
module ad_ip_jesd204_tpl_adc_pnmon_deframer #(
    parameter int NUM_LANES            = 4,
    parameter int NUM_CHANNELS         = 2,
    parameter int OCTETS_PER_BEAT      = 4,
    parameter int CONVERTER_RESOLUTION = 14,
    localparam int DATA_PATH_WIDTH     = OCTETS_PER_BEAT * 8 * NUM_LANES / NUM_CHANNELS / 16,
    localparam int LINK_DATA_WIDTH     = NUM_LANES * OCTETS_PER_BEAT * 8
) (
    input  logic                                         link_clk,
    input  logic                                         link_reset,
    input  logic                                         link_valid,
    input  logic [LINK_DATA_WIDTH-1:0]                   link_data,
    input  logic [NUM_CHANNELS-1:0]                      adc_enable,
    input  logic                                         adc_dfmt_enable,
    input  logic                                         adc_dfmt_se,
    input  logic [2*NUM_CHANNELS-1:0]                    adc_pn_sel,
    output logic                                         adc_valid,
    output logic [16*DATA_PATH_WIDTH*NUM_CHANNELS-1:0]   adc_data,
    output logic [NUM_CHANNELS-1:0]                      adc_pn_oos,
    output logic [NUM_CHANNELS-1:0]                      adc_pn_err
);

    localparam int NUM_WORDS = LINK_DATA_WIDTH / 16;
    localparam int SIGN_BIT  = CONVERTER_RESOLUTION - 1;
    localparam int TAIL_BITS = 16 - CONVERTER_RESOLUTION;

    typedef enum logic {
        PN_OOS  = 1'b0,
        PN_SYNC = 1'b1
    } pn_state_t;

    // Right-align the N-bit converter value, optionally flip its MSB
    // (offset binary to two's complement), then sign- or zero-extend.
    function automatic logic [15:0] format_sample(input logic [15:0] word,
                                                  input logic       dfmt_en,
                                                  input logic       sign_ext);
        logic [15:0] raw;
        logic        msb;
        logic [15:0] res;
        raw = word >> TAIL_BITS;
        if (dfmt_en) begin
            raw[SIGN_BIT] = ~raw[SIGN_BIT];
        end
        msb = raw[SIGN_BIT];
        res = '0;
        for (int b = 0; b < 16; b++) begin
            res[b] = (b < CONVERTER_RESOLUTION) ? raw[b] : (sign_ext & msb);
        end
        return res;
    endfunction

    // Run the PN recurrence for 16 steps from the previous word. The
    // register holds the newest bit in bit 0, so b[n-k] sits at bit k-1.
    function automatic logic [15:0] pn_next(input logic [15:0] prev,
                                            input logic        pn15);
        logic [15:0] s;
        logic        nb;
        s = prev;
        for (int i = 0; i < 16; i++) begin
            nb = pn15 ? (s[14] ^ s[13]) : (s[8] ^ s[4]);
            s  = {s[14:0], nb};
        end
        return s;
    endfunction

    // A beat matches only if every sample follows from its predecessor;
    // sample 0 is predicted from the last sample of the previous beat.
    function automatic logic beat_matches(input logic [15:0] prev,
                                          input logic [DATA_PATH_WIDTH-1:0][15:0] samples,
                                          input logic pn15);
        logic        ok;
        logic [15:0] pred_src;
        ok       = 1'b1;
        pred_src = prev;
        for (int s = 0; s < DATA_PATH_WIDTH; s++) begin
            if (pn_next(pred_src, pn15) != samples[s]) begin
                ok = 1'b0;
            end
            pred_src = samples[s];
        end
        return ok;
    endfunction

    function automatic logic pn_off(input logic [1:0] sel);
        return (sel == 2'd0) || (sel == 2'd3);
    endfunction

    logic [NUM_WORDS-1:0][15:0] beat_word;
    logic [NUM_WORDS-1:0][15:0] beat_fmt;
    logic [NUM_WORDS-1:0][15:0] stage_word;

    pn_state_t                  state_q [NUM_CHANNELS];
    pn_state_t                  state_d [NUM_CHANNELS];
    logic [4:0]                 good_q  [NUM_CHANNELS];
    logic [4:0]                 good_d  [NUM_CHANNELS];
    logic [2:0]                 bad_q   [NUM_CHANNELS];
    logic [2:0]                 bad_d   [NUM_CHANNELS];
    logic [15:0]                prev_q  [NUM_CHANNELS];
    logic [15:0]                prev_d  [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]    err_q;
    logic [NUM_CHANNELS-1:0]    err_d;
    logic [NUM_CHANNELS-1:0]    beat_match;
    logic [2*NUM_CHANNELS-1:0]  sel_q;

    // Byte-swap each 16-bit lane word (first octet is the MSB) and format it.
    always_comb begin
        beat_word = '0;
        beat_fmt  = '0;
        for (int w = 0; w < NUM_WORDS; w++) begin
            beat_word[w] = {link_data[16*w +: 8], link_data[16*w+8 +: 8]};
            beat_fmt[w]  = adc_enable[w / DATA_PATH_WIDTH]
                         ? format_sample(beat_word[w], adc_dfmt_enable, adc_dfmt_se)
                         : 16'h0000;
        end
    end

    // First stage: register formatted output and the raw words for PN checking.
    always_ff @(posedge link_clk) begin
        if (link_reset) begin
            adc_valid  <= 1'b0;
            adc_data   <= '0;
            stage_word <= '0;
        end else begin
            adc_valid <= link_valid;
            if (link_valid) begin
                adc_data   <= beat_fmt;
                stage_word <= beat_word;
            end
        end
    end

    // Per-channel PN compare and OOS/SYNC next-state logic on the staged beat.
    always_comb begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            state_d[c] = state_q[c];
            good_d[c]  = good_q[c];
            bad_d[c]   = bad_q[c];
            prev_d[c]  = prev_q[c];
            err_d[c]   = 1'b0;
            beat_match[c] = beat_matches(prev_q[c],
                                         stage_word[c*DATA_PATH_WIDTH +: DATA_PATH_WIDTH],
                                         adc_pn_sel[2*c +: 2] == 2'd2);
            if (adc_valid) begin
                prev_d[c] = stage_word[c*DATA_PATH_WIDTH + DATA_PATH_WIDTH - 1];
            end
            if (!adc_enable[c] || pn_off(adc_pn_sel[2*c +: 2]) ||
                (adc_pn_sel[2*c +: 2] != sel_q[2*c +: 2])) begin
                state_d[c] = PN_OOS;
                good_d[c]  = 5'd0;
                bad_d[c]   = 3'd0;
            end else if (adc_valid) begin
                case (state_q[c])
                    PN_OOS: begin
                        if (beat_match[c]) begin
                            if (good_q[c] == 5'd15) begin
                                state_d[c] = PN_SYNC;
                                good_d[c]  = 5'd0;
                            end else begin
                                good_d[c] = good_q[c] + 5'd1;
                            end
                        end else begin
                            good_d[c] = 5'd0;
                        end
                    end
                    PN_SYNC: begin
                        if (beat_match[c]) begin
                            bad_d[c] = 3'd0;
                        end else begin
                            err_d[c] = 1'b1;
                            if (bad_q[c] == 3'd3) begin
                                state_d[c] = PN_OOS;
                                bad_d[c]   = 3'd0;
                            end else begin
                                bad_d[c] = bad_q[c] + 3'd1;
                            end
                        end
                    end
                endcase
            end
        end
    end

    // Second stage: PN monitor state, counters and previous-word history.
    always_ff @(posedge link_clk) begin
        if (link_reset) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                state_q[c] <= PN_OOS;
                good_q[c]  <= 5'd0;
                bad_q[c]   <= 3'd0;
                prev_q[c]  <= 16'h0000;
            end
            err_q <= '0;
            sel_q <= '0;
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                state_q[c] <= state_d[c];
                good_q[c]  <= good_d[c];
                bad_q[c]   <= bad_d[c];
                prev_q[c]  <= prev_d[c];
            end
            err_q <= err_d;
            sel_q <= adc_pn_sel;
        end
    end

    // Status outputs straight from the registered monitor state.
    always_comb begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            adc_pn_oos[c] = (state_q[c] == PN_OOS);
        end
    end

    assign adc_pn_err = err_q;

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_adc_pnmon_deframer.sv
// Testbench for the ADC transport-layer deframer with PN monitor.
// A behavioural model built from bit streams and integer arithmetic
// predicts every output each cycle; directed steps cover the key cases.
module tb_ad_ip_jesd204_tpl_adc_pnmon_deframer;

    localparam int NL  = 4;
    localparam int NC  = 2;
    localparam int OPB = 4;
    localparam int N   = 14;
    localparam int DPW = 4;
    localparam int LDW = 128;
    localparam int NW  = 8;

    logic             clk = 1'b0;
    logic             link_reset;
    logic             link_valid;
    logic [LDW-1:0]   link_data;
    logic [NC-1:0]    adc_enable;
    logic             adc_dfmt_enable;
    logic             adc_dfmt_se;
    logic [2*NC-1:0]  adc_pn_sel;
    logic             adc_valid;
    logic [LDW-1:0]   adc_data;
    logic [NC-1:0]    adc_pn_oos;
    logic [NC-1:0]    adc_pn_err;

    int total = 0;
    int bad   = 0;
    int err_seen0 = 0;
    int err_seen_all = 0;

    logic [15:0] words [NW];
    logic [15:0] gen_prev [NC];
    bit          gen_pn15 [NC];

    // model state
    logic           m_valid;
    logic [LDW-1:0] m_data;
    logic [NC-1:0]  m_sync;
    logic [NC-1:0]  m_err;
    logic           m_s1_valid;
    logic [15:0]    m_s1_words [NW];
    logic [15:0]    m_prev [NC];
    int             m_good [NC];
    int             m_bad  [NC];
    logic [1:0]     m_last_sel [NC];

    ad_ip_jesd204_tpl_adc_pnmon_deframer #(
        .NUM_LANES(NL),
        .NUM_CHANNELS(NC),
        .OCTETS_PER_BEAT(OPB),
        .CONVERTER_RESOLUTION(N)
    ) dut (
        .link_clk(clk),
        .link_reset(link_reset),
        .link_valid(link_valid),
        .link_data(link_data),
        .adc_enable(adc_enable),
        .adc_dfmt_enable(adc_dfmt_enable),
        .adc_dfmt_se(adc_dfmt_se),
        .adc_pn_sel(adc_pn_sel),
        .adc_valid(adc_valid),
        .adc_data(adc_data),
        .adc_pn_oos(adc_pn_oos),
        .adc_pn_err(adc_pn_err)
    );

    // free-running link clock
    always #5 clk = ~clk;

    // Extend the bit stream from the 16 bits of prev (MSB is oldest).
    function automatic logic [15:0] model_pn(input logic [15:0] prev, input bit pn15);
        bit          b [32];
        logic [15:0] r;
        for (int i = 0; i < 16; i++) b[i] = prev[15-i];
        for (int n = 16; n < 32; n++)
            b[n] = pn15 ? (b[n-15] ^ b[n-14]) : (b[n-9] ^ b[n-5]);
        r = '0;
        for (int i = 0; i < 16; i++) r[15-i] = b[16+i];
        return r;
    endfunction

    function automatic logic [15:0] model_fmt(input logic [15:0] word, input bit dfmt, input bit se);
        int v;
        v = int'(word) >> (16 - N);
        if (dfmt) v = v ^ (1 << (N - 1));
        if (se && v >= (1 << (N - 1))) v = v - (1 << N);
        return v[15:0];
    endfunction

    task automatic model_update();
        logic [15:0] pred;
        bit          match;
        logic [1:0]  sel;
        bit          off;
        bit          chg;
        if (link_reset) begin
            m_valid = 1'b0;
            m_data = '0;
            m_sync = '0;
            m_err = '0;
            m_s1_valid = 1'b0;
            for (int w = 0; w < NW; w++) m_s1_words[w] = 16'h0;
            for (int c = 0; c < NC; c++) begin
                m_prev[c] = 16'h0;
                m_good[c] = 0;
                m_bad[c] = 0;
                m_last_sel[c] = 2'd0;
            end
        end else begin
            for (int c = 0; c < NC; c++) begin
                sel = adc_pn_sel[2*c +: 2];
                off = (sel == 2'd0) || (sel == 2'd3);
                chg = (sel != m_last_sel[c]);
                m_err[c] = 1'b0;
                match = 1'b1;
                for (int s = 0; s < DPW; s++) begin
                    pred = model_pn((s == 0) ? m_prev[c] : m_s1_words[c*DPW+s-1], sel == 2'd2);
                    if (pred != m_s1_words[c*DPW+s]) match = 1'b0;
                end
                if (!adc_enable[c] || off || chg) begin
                    m_sync[c] = 1'b0;
                    m_good[c] = 0;
                    m_bad[c] = 0;
                end else if (m_s1_valid) begin
                    if (!m_sync[c]) begin
                        if (match) begin
                            m_good[c]++;
                            if (m_good[c] == 16) begin
                                m_sync[c] = 1'b1;
                                m_good[c] = 0;
                            end
                        end else begin
                            m_good[c] = 0;
                        end
                    end else if (match) begin
                        m_bad[c] = 0;
                    end else begin
                        m_err[c] = 1'b1;
                        m_bad[c]++;
                        if (m_bad[c] == 4) begin
                            m_sync[c] = 1'b0;
                            m_bad[c] = 0;
                        end
                    end
                end
                if (m_s1_valid) m_prev[c] = m_s1_words[c*DPW+DPW-1];
                m_last_sel[c] = sel;
            end
            m_valid = link_valid;
            m_s1_valid = link_valid;
            if (link_valid) begin
                for (int w = 0; w < NW; w++) begin
                    m_s1_words[w] = words[w];
                    m_data[16*w +: 16] = adc_enable[w/DPW]
                        ? model_fmt(words[w], adc_dfmt_enable, adc_dfmt_se) : 16'h0;
                end
            end
        end
    endtask

    task automatic check_output();
        total++;
        assert (adc_valid === m_valid) else begin
            bad++;
            $error("FAIL adc_valid got=%b exp=%b", adc_valid, m_valid);
        end
        total++;
        assert (adc_data === m_data) else begin
            bad++;
            $error("FAIL adc_data got=%h exp=%h", adc_data, m_data);
        end
        total++;
        assert (adc_pn_oos === ~m_sync) else begin
            bad++;
            $error("FAIL adc_pn_oos got=%b exp=%b", adc_pn_oos, ~m_sync);
        end
        total++;
        assert (adc_pn_err === m_err) else begin
            bad++;
            $error("FAIL adc_pn_err got=%b exp=%b", adc_pn_err, m_err);
        end
        if (adc_pn_err[0] === 1'b1) err_seen0++;
        if (adc_pn_err !== 2'b00) err_seen_all++;
    endtask

    task automatic check_value(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic apply_stimulus(input bit valid);
        link_valid = valid;
        for (int w = 0; w < NW; w++) begin
            link_data[16*w +: 8]   = words[w][15:8];
            link_data[16*w+8 +: 8] = words[w][7:0];
        end
    endtask

    // one clock: model follows the edge, outputs checked shortly after
    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        check_output();
    endtask

    task automatic fill_beat(input bit pn0, input bit pn1);
        for (int c = 0; c < NC; c++) begin
            for (int s = 0; s < DPW; s++) begin
                if ((c == 0) ? pn0 : pn1) begin
                    gen_prev[c] = model_pn(gen_prev[c], gen_pn15[c]);
                    words[c*DPW+s] = gen_prev[c];
                end else begin
                    words[c*DPW+s] = 16'($urandom);
                end
            end
        end
    endtask

    task automatic pn_beats(input int n, input bit pn0, input bit pn1);
        for (int i = 0; i < n; i++) begin
            fill_beat(pn0, pn1);
            apply_stimulus(1'b1);
            tick();
        end
    endtask

    initial begin
        int vcount;
        int iter;
        bit v;
        link_reset = 1'b1;
        link_valid = 1'b0;
        link_data = '0;
        adc_enable = 2'b11;
        adc_dfmt_enable = 1'b1;
        adc_dfmt_se = 1'b1;
        adc_pn_sel = 4'b0000;
        for (int w = 0; w < NW; w++) words[w] = 16'h0;
        for (int c = 0; c < NC; c++) begin
            gen_prev[c] = 16'($urandom) | 16'h0001;
            gen_pn15[c] = 1'b0;
        end

        // reset
        apply_stimulus(1'b0);
        repeat (3) tick();
        check_value("reset_oos", 128'(adc_pn_oos), 128'(2'b11));
        check_value("reset_data", adc_data, 128'h0);
        link_reset = 1'b0;
        tick();

        // formatting of word 0 = 0x1234
        for (int w = 0; w < NW; w++) words[w] = 16'($urandom);
        words[0] = 16'h1234;
        apply_stimulus(1'b1);
        tick();
        check_value("fmt_se", 128'(adc_data[15:0]), 128'(16'hE48D));
        adc_dfmt_se = 1'b0;
        tick();
        check_value("fmt_zero", 128'(adc_data[15:0]), 128'(16'h248D));
        adc_dfmt_enable = 1'b0;
        tick();
        check_value("fmt_raw", 128'(adc_data[15:0]), 128'(16'h048D));

        // deinterleave order
        for (int w = 0; w < NW; w++) words[w] = 16'h0400 + 16'(w << 2);
        apply_stimulus(1'b1);
        tick();
        check_value("deinterleave", adc_data, 128'h0107_0106_0105_0104_0103_0102_0101_0100);
        apply_stimulus(1'b0);
        tick();
        check_value("hold", adc_data, 128'h0107_0106_0105_0104_0103_0102_0101_0100);

        // random formatting, enables and gaps
        for (int i = 0; i < 24; i++) begin
            for (int w = 0; w < NW; w++) words[w] = 16'($urandom);
            adc_enable = 2'($urandom);
            adc_dfmt_enable = 1'($urandom);
            adc_dfmt_se = 1'($urandom);
            apply_stimulus($urandom_range(0, 3) != 0);
            tick();
        end
        adc_enable = 2'b11;

        // PN9 lock on channel 0, channel 1 off
        $display("[TB] PN9 lock");
        adc_pn_sel = 4'b0001;
        gen_pn15[0] = 1'b0;
        apply_stimulus(1'b0);
        tick();
        pn_beats(20, 1'b1, 1'b0);
        check_value("pn9_lock", 128'(adc_pn_oos), 128'(2'b10));

        // single corrupted beat
        err_seen0 = 0;
        fill_beat(1'b1, 1'b0);
        words[1] = words[1] ^ 16'h0010;
        apply_stimulus(1'b1);
        tick();
        pn_beats(4, 1'b1, 1'b0);
        check_value("single_err_cnt", 128'(err_seen0), 128'(1));
        check_value("single_err_oos", 128'(adc_pn_oos), 128'(2'b10));

        // four corrupted beats lose sync
        err_seen0 = 0;
        for (int i = 0; i < 4; i++) begin
            fill_beat(1'b1, 1'b0);
            words[1] = words[1] ^ 16'h0100;
            apply_stimulus(1'b1);
            tick();
        end
        pn_beats(1, 1'b1, 1'b0);
        check_value("loss_err_cnt", 128'(err_seen0), 128'(4));
        check_value("loss_oos", 128'(adc_pn_oos), 128'(2'b11));
        pn_beats(2, 1'b1, 1'b0);

        // PN15 on both channels with random gaps
        $display("[TB] PN15 with gaps");
        adc_pn_sel = 4'b1010;
        gen_pn15[0] = 1'b1;
        gen_pn15[1] = 1'b1;
        err_seen_all = 0;
        vcount = 0;
        iter = 0;
        while (vcount < 30 && iter < 200) begin
            v = ($urandom_range(0, 2) != 0);
            if (v) begin
                fill_beat(1'b1, 1'b1);
                vcount++;
            end
            apply_stimulus(v);
            tick();
            iter++;
        end
        apply_stimulus(1'b0);
        tick();
        tick();
        check_value("gap_beats", 128'(vcount), 128'(30));
        check_value("pn15_lock", 128'(adc_pn_oos), 128'(2'b00));
        check_value("pn15_no_err", 128'(err_seen_all), 128'(0));

        // reset while in sync
        fill_beat(1'b1, 1'b1);
        apply_stimulus(1'b1);
        link_reset = 1'b1;
        tick();
        check_value("rst_oos", 128'(adc_pn_oos), 128'(2'b11));
        check_value("rst_valid", 128'(adc_valid), 128'(0));
        link_reset = 1'b0;
        pn_beats(20, 1'b1, 1'b1);
        check_value("relock", 128'(adc_pn_oos), 128'(2'b00));

        // PN9 lock on channel 0, then switch its selection to PN15
        adc_pn_sel = 4'b1001;
        gen_pn15[0] = 1'b0;
        gen_prev[0] = 16'($urandom) | 16'h0001;
        pn_beats(20, 1'b1, 1'b1);
        check_value("pn9_relock", 128'(adc_pn_oos), 128'(2'b00));
        adc_pn_sel = 4'b1010;
        pn_beats(1, 1'b1, 1'b1);
        check_value("sel_change", 128'(adc_pn_oos), 128'(2'b01));
        pn_beats(3, 1'b1, 1'b1);
        check_value("sel_change_stay", 128'(adc_pn_oos), 128'(2'b01));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
